// File: rtl/fp_addsub_seq.sv
// Multi-cycle parametrised floating-point adder/subtractor with start/done handshake.
// Optional status flags output enabled by defining FP_ADDSUB_FLAGS_EN.
module fp_addsub_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result
`ifdef FP_ADDSUB_FLAGS_EN
    ,
    output logic [3:0]             flags
`endif
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned ExtW = MAN_W + 4;
    localparam logic [EXP_W-1:0] ExpMax   = '1;
    localparam logic [EXP_W:0]   ExpOne   = 1;
    localparam logic [MAN_W-1:0] QNanFrac = {1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StSpecial, StAlign, StAdd, StNorm, StRound, StDone
    } state_e;

    state_e            state_q;
    logic [W-1:0]      a_q, b_q;
    logic              op_q, sign_q, sub_q;
    logic [EXP_W:0]    exp_q;
    logic [ExtW:0]     mx_q;
    logic [ExtW-1:0]   my_q;

    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, spec_nan, is_special;
    logic [W-1:0]      spec_res;

    assign sa = a_q[W-1];
    assign sb = b_q[W-1] ^ op_q;
    assign ea = a_q[W-2:MAN_W];
    assign eb = b_q[W-2:MAN_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    // Denormals (exp==0) count as zero.
    assign a_nan  = (ea == ExpMax) && (fa != '0);
    assign b_nan  = (eb == ExpMax) && (fb != '0);
    assign a_inf  = (ea == ExpMax) && (fa == '0);
    assign b_inf  = (eb == ExpMax) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign spec_nan   = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
    assign is_special = spec_nan | a_inf | b_inf | a_zero | b_zero;

    always_comb begin
        spec_res = '0;
        if (spec_nan)             spec_res = {1'b0, ExpMax, QNanFrac};
        else if (a_inf)           spec_res = {sa, a_q[W-2:0]};
        else if (b_inf)           spec_res = {sb, b_q[W-2:0]};
        else if (a_zero && b_zero) spec_res = {sa & sb, {(W-1){1'b0}}};
        else if (a_zero)          spec_res = {sb, b_q[W-2:0]};
        else if (b_zero)          spec_res = {sa, a_q[W-2:0]};
    end

    logic              a_ge, sx, sy, y_lost;
    logic [EXP_W-1:0]  ex, ey, d;
    logic [ExtW-1:0]   x_ext, y_ext, y_sh, y_al;

    assign a_ge  = a_q[W-2:0] >= b_q[W-2:0];
    assign sx    = a_ge ? sa : sb;
    assign sy    = a_ge ? sb : sa;
    assign ex    = a_ge ? ea : eb;
    assign ey    = a_ge ? eb : ea;
    assign x_ext = {1'b1, (a_ge ? fa : fb), 3'b000};
    assign y_ext = {1'b1, (a_ge ? fb : fa), 3'b000};
    assign d     = ex - ey;
    assign y_sh  = y_ext >> d;
    assign y_lost = |(y_ext & ~({ExtW{1'b1}} << d));
    // Far-apart operands collapse to a lone sticky bit.
    assign y_al  = (int'(d) >= int'(MAN_W) + 3) ? {{(ExtW-1){1'b0}}, 1'b1}
                                                : {y_sh[ExtW-1:1], y_sh[0] | y_lost};

    logic [ExtW:0] sum;
    assign sum = sub_q ? (mx_q - {1'b0, my_q}) : (mx_q + {1'b0, my_q});

    logic [MAN_W:0]   keep;
    logic [MAN_W-1:0] frac_r;
    logic             g, r, s, inc, rnd_carry, ovf;
    logic [EXP_W:0]   exp_r;
    logic [W-1:0]     rnd_res;

    assign keep      = mx_q[ExtW-1:3];
    assign g         = mx_q[2];
    assign r         = mx_q[1];
    assign s         = mx_q[0];
    assign inc       = g & (r | s | keep[0]);
    assign rnd_carry = (&keep) & inc;
    assign frac_r    = keep[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, inc};
    assign exp_r     = exp_q + {{EXP_W{1'b0}}, rnd_carry};
    assign ovf       = exp_r >= {1'b0, ExpMax};
    assign rnd_res   = ovf ? {sign_q, ExpMax, {MAN_W{1'b0}}}
                           : {sign_q, exp_r[EXP_W-1:0], frac_r};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
            flags   <= 4'b0000;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        busy    <= 1'b1;
                        state_q <= StSpecial;
                    end
                end
                StSpecial: begin
                    if (is_special) begin
                        result  <= spec_res;
`ifdef FP_ADDSUB_FLAGS_EN
                        flags   <= {spec_nan, 3'b000};
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StAlign;
                    end
                end
                StAlign: begin
                    sign_q  <= sx;
                    sub_q   <= sx ^ sy;
                    exp_q   <= {1'b0, ex};
                    mx_q    <= {1'b0, x_ext};
                    my_q    <= y_al;
                    state_q <= StAdd;
                end
                StAdd: begin
                    if (sum == '0) begin
                        result  <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
                        flags   <= 4'b0000;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        mx_q    <= sum;
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    if (mx_q[ExtW]) begin
                        mx_q    <= {1'b0, mx_q[ExtW:2], mx_q[1] | mx_q[0]};
                        exp_q   <= exp_q + ExpOne;
                        state_q <= StRound;
                    end else if (mx_q[ExtW-1]) begin
                        state_q <= StRound;
                    end else if (exp_q == ExpOne) begin
                        result  <= {sign_q, {(W-1){1'b0}}};
`ifdef FP_ADDSUB_FLAGS_EN
                        flags   <= 4'b0011;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        mx_q    <= mx_q << 1;
                        exp_q   <= exp_q - ExpOne;
                    end
                end
                StRound: begin
                    result  <= rnd_res;
`ifdef FP_ADDSUB_FLAGS_EN
                    flags   <= {1'b0, ovf, 1'b0, g | r | s | ovf};
`endif
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: transaction-level reference model checked every cycle
// plus directed vectors with literal results, latencies and flags.
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]  flags;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result)
`ifdef FP_ADDSUB_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference arithmetic: flags = {invalid, overflow, underflow, inexact}.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                                  output logic [31:0] res, output int lat,
                                  output logic [3:0] fl);
        logic   sa, sb, sx, sy;
        int     ea, eb, ex, ey, dd, e, n;
        longint fa, fb, mx, my, lost, sum, keep, grs;
        bit     ov, uf, nan_a, nan_b, inf_a, inf_b;
        sa = av[31];
        sb = bv[31] ^ opv;
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        fa = longint'(av[22:0]);
        fb = longint'(bv[22:0]);
        nan_a = (ea == 255) && (fa != 0);
        nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);
        inf_b = (eb == 255) && (fb == 0);
        res = '0;
        lat = 2;
        fl  = 4'b0000;
        if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
            res = 32'h7FC0_0000;
            fl  = 4'b1000;
        end else if (inf_a)              res = {sa, av[30:0]};
        else if (inf_b)                  res = {sb, bv[30:0]};
        else if (ea == 0 && eb == 0)     res = {sa & sb, 31'b0};
        else if (ea == 0)                res = {sb, bv[30:0]};
        else if (eb == 0)                res = {sa, av[30:0]};
        else begin
            if (av[30:0] >= bv[30:0]) begin
                ex = ea; ey = eb; sx = sa; sy = sb;
                mx = ((64'd1 << 23) | fa) << 3;
                my = ((64'd1 << 23) | fb) << 3;
            end else begin
                ex = eb; ey = ea; sx = sb; sy = sa;
                mx = ((64'd1 << 23) | fb) << 3;
                my = ((64'd1 << 23) | fa) << 3;
            end
            dd = ex - ey;
            if (dd >= 26) my = 1;
            else begin
                lost = my & ((64'd1 << dd) - 1);
                my = (my >> dd) | ((lost != 0) ? 64'd1 : 64'd0);
            end
            sum = (sx == sy) ? mx + my : mx - my;
            if (sum == 0) begin
                lat = 4;
            end else begin
                e = ex; n = 0; uf = 0;
                if (sum >= (64'd1 << 27)) begin
                    sum = (sum >> 1) | (sum & 1);
                    e++;
                end else begin
                    while (!uf && sum < (64'd1 << 26)) begin
                        if (e == 1) uf = 1;
                        else begin
                            sum = sum << 1;
                            e--;
                            n++;
                        end
                    end
                end
                if (uf) begin
                    res = {sx, 31'b0};
                    lat = 5 + n;
                    fl  = 4'b0011;
                end else begin
                    grs  = sum & 7;
                    keep = sum >> 3;
                    if ((grs & 4) != 0 && ((grs & 3) != 0 || (keep & 1) != 0)) keep++;
                    if (keep >= (64'd1 << 24)) begin
                        keep = keep >> 1;
                        e++;
                    end
                    ov  = (e >= 255);
                    res = ov ? {sx, 8'hFF, 23'b0} : {sx, e[7:0], keep[22:0]};
                    lat = 6 + n;
                    fl  = {1'b0, ov, 1'b0, (grs != 0) || ov};
                end
            end
        end
    endfunction

    // Transaction model: tracks acceptance, latency and held outputs.
    int          m_cnt = 0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_result = '0, p_res = '0;
    logic [3:0]  m_flags = '0, p_fl = '0;
    bit          chk_en = 0;

    initial forever begin
        logic prev_done;
        int   lat;
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_busy = 0; m_done = 0; m_result = '0; m_flags = '0;
        end else begin
            prev_done = m_done;
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1; m_busy = 0; m_result = p_res; m_flags = p_fl;
                end
            end else if (start && !prev_done) begin
                model(a, b, op, p_res, lat, p_fl);
                m_cnt  = lat - 1;
                m_busy = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_result", result, m_result);
`ifdef FP_ADDSUB_FLAGS_EN
            check("cyc_flags", flags, m_flags);
`endif
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic do_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input logic opv, input logic [31:0] want, input int want_lat,
                         input logic [3:0] want_fl);
        int          cyc, mlat;
        logic [31:0] mres;
        logic [3:0]  mfl;
        model(av, bv, opv, mres, mlat, mfl);
        check({nm, "_model_res"}, mres, want);
        check({nm, "_model_lat"}, mlat, want_lat);
        check({nm, "_model_flags"}, mfl, want_fl);
        a = av; b = bv; op = opv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({nm, "_busy1"}, busy, 1);
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_lat"}, cyc, want_lat);
        check({nm, "_res"}, result, want);
        check({nm, "_busy_at_done"}, busy, 0);
`ifdef FP_ADDSUB_FLAGS_EN
        check({nm, "_flags"}, flags, want_fl);
`endif
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        do_op("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 6, 4'b0000);
        do_op("one_minus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4, 4'b0000);
        do_op("ulp_diff", 32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 29, 4'b0000);
        do_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 2, 4'b1000);
        do_op("negz_minus_z", 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 2, 4'b0000);
        do_op("tie_even", 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 6, 4'b0001);
        do_op("round_up", 32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 6, 4'b0001);
        do_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 6, 4'b0101);
        do_op("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 2, 4'b1000);
        do_op("fin_minus_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 2, 4'b0000);
        do_op("zero_minus_b", 32'h0000_0000, 32'h4000_0000, 1'b1, 32'hC000_0000, 2, 4'b0000);
        do_op("denorm_plus", 32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 2, 4'b0000);
        do_op("underflow", 32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 5, 4'b0011);
        do_op("tie_carry", 32'h3F80_0000, 32'hB300_0000, 1'b0, 32'h3F80_0000, 7, 4'b0001);
        do_op("one_minus_two", 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 7, 4'b0000);

        // start while busy and while done must be ignored
        a = 32'h3F80_0000; b = 32'h4000_0000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        @(negedge clk);
        @(negedge clk);
        cyc = 3;
        a = 32'h0000_0000; b = 32'h7F80_0000; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("poke_lat", cyc, 6);
        check("poke_res", result, 32'h4040_0000);
        a = 32'h3F80_0000; b = 32'h3F80_0000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_busy", busy, 0);
        check("start_in_done_res", result, 32'h4040_0000);
        @(negedge clk);
        check("start_in_done_idle", busy, 0);

        // reset mid-operation
        a = 32'h3F80_0000; b = 32'h4000_0000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_stays_idle", busy, 0);
        do_op("after_rst", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 6, 4'b0000);

        // reset beats a simultaneous start
        a = 32'h3F80_0000; b = 32'h4000_0000; op = 1'b0; start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        check("rst_vs_start", busy, 0);
        @(negedge clk);
        check("rst_vs_start_idle", busy, 0);
        do_op("final", 32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 7, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
